// File: rtl/hilo_mult_unit.sv
// HI/LO multiply/accumulate unit for the EX stage.
// Iterative shift-add multiplier (one bit per cycle) with signed/unsigned mult, madd, msub, mthi, mtlo.
module hilo_mult_unit #(
    parameter int unsigned N_ITER = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  hilo_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        done
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned PLEN  = 2 * XLEN;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned OP_W  = 3;

    localparam logic [OP_W-1:0] OP_NONE  = 3'd0;
    localparam logic [OP_W-1:0] OP_MULT  = 3'd1;
    localparam logic [OP_W-1:0] OP_MULTU = 3'd2;
    localparam logic [OP_W-1:0] OP_MADD  = 3'd3;
    localparam logic [OP_W-1:0] OP_MSUB  = 3'd4;
    localparam logic [OP_W-1:0] OP_MTHI  = 3'd5;
    localparam logic [OP_W-1:0] OP_MTLO  = 3'd6;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ACC  = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  iter_cnt;
    logic [PLEN-1:0]   acc;
    logic [PLEN-1:0]   mcand;
    logic [XLEN-1:0]   mplier;
    logic              negate;
    logic [OP_W-1:0]   op_q;

    logic              is_mul_op_c;
    logic              is_signed_op_c;
    logic              is_mt_op_c;
    logic [XLEN-1:0]   a_mag_c;
    logic [XLEN-1:0]   b_mag_c;
    logic [PLEN-1:0]   prod_c;
    logic [PLEN-1:0]   hilo_c;
    logic [PLEN-1:0]   wb_c;

    // Request decode on the live operation select.
    always_comb begin
        is_mul_op_c    = 1'b0;
        is_signed_op_c = 1'b0;
        is_mt_op_c     = 1'b0;
        case (hilo_op)
            OP_MULT, OP_MADD, OP_MSUB: begin
                is_mul_op_c    = 1'b1;
                is_signed_op_c = 1'b1;
            end
            OP_MULTU:         is_mul_op_c = 1'b1;
            OP_MTHI, OP_MTLO: is_mt_op_c  = 1'b1;
            default: ;
        endcase
    end

    // |0x80000000| wraps back to 0x80000000, which is the correct unsigned magnitude.
    always_comb begin
        a_mag_c = a;
        b_mag_c = b;
        if (is_signed_op_c && a[XLEN-1]) a_mag_c = ~a + XLEN'(1);
        if (is_signed_op_c && b[XLEN-1]) b_mag_c = ~b + XLEN'(1);
    end

    // Final sign fix-up and HI/LO writeback value for the ACC cycle.
    always_comb begin
        prod_c = negate ? (~acc + PLEN'(1)) : acc;
        hilo_c = {hi, lo};
        case (op_q)
            OP_MADD: wb_c = hilo_c + prod_c;
            OP_MSUB: wb_c = hilo_c - prod_c;
            default: wb_c = prod_c;
        endcase
    end

    assign stall = busy | (start & is_mul_op_c);
    assign done  = (state == S_ACC) | ((state == S_IDLE) & start & is_mt_op_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            iter_cnt <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            negate   <= 1'b0;
            op_q     <= OP_NONE;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (is_mul_op_c) begin
                            mcand    <= PLEN'(a_mag_c);
                            mplier   <= b_mag_c;
                            negate   <= is_signed_op_c & (a[XLEN-1] ^ b[XLEN-1]);
                            op_q     <= hilo_op;
                            iter_cnt <= '0;
                            acc      <= '0;
                            busy     <= 1'b1;
                            state    <= S_MUL;
                        end else if (hilo_op == OP_MTHI) begin
                            hi <= a;
                        end else if (hilo_op == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                S_MUL: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand    <= mcand << 1;
                    mplier   <= mplier >> 1;
                    iter_cnt <= iter_cnt + CNT_W'(1);
                    if (iter_cnt == LAST_ITER) state <= S_ACC;
                end
                S_ACC: begin
                    {hi, lo} <= wb_c;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
